// File: rtl/mem_port_arbiter.sv
// Merges NUM_CH request/valid channels onto one memory port with fixed-priority
// or round-robin arbitration, latched request fields and an optional timeout.
module mem_port_arbiter #(
   parameter int NUM_CH    = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MASK_W    = DATA_W / 8,
   parameter int PRIO_MODE = 0,
   parameter int TIMEOUT   = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          ch_request,
   input  logic [NUM_CH-1:0]          ch_we_re,
   input  logic [NUM_CH*MASK_W-1:0]   ch_mask,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
   input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
   output logic [NUM_CH-1:0]          ch_valid,
   output logic                       ch_error,
   output logic [DATA_W-1:0]          ch_rdata,
   output logic                       mem_request,
   output logic                       mem_we_re,
   output logic [MASK_W-1:0]          mem_mask,
   output logic [ADDR_W-1:0]          mem_address,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic                       mem_valid,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic [$clog2(NUM_CH)-1:0]  grant_id,
   output logic                       busy
);

   localparam int GID_W = $clog2(NUM_CH);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // The counter fires on the cycle it would have reached TIMEOUT, so mem_request
   // stays high for exactly TIMEOUT cycles.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP
   } state_t;

   state_t             state, state_d;
   logic [GID_W-1:0]   last_grant, last_grant_d;
   logic [GID_W-1:0]   grant_id_d;
   logic [CNT_W-1:0]   to_cnt, to_cnt_d;
   logic               mem_request_d, mem_we_re_d;
   logic [MASK_W-1:0]  mem_mask_d;
   logic [ADDR_W-1:0]  mem_address_d;
   logic [DATA_W-1:0]  mem_wdata_d;
   logic [NUM_CH-1:0]  ch_valid_d;
   logic               ch_error_d;
   logic [DATA_W-1:0]  ch_rdata_d;
   logic               busy_d;

   logic               win_found;
   logic [GID_W-1:0]   win_id;

   // Winner selection. Loops run from the far end so the last hit is the preferred one.
   always_comb begin
      int idx;
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      if (PRIO_MODE == 0) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_request[i]) begin
               win_found = 1'b1;
               win_id    = GID_W'(i);
            end
         end
      end else begin
         for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % NUM_CH;
            if (ch_request[idx]) begin
               win_found = 1'b1;
               win_id    = GID_W'(idx);
            end
         end
      end
   end

   always_comb begin
      state_d       = state;
      last_grant_d  = last_grant;
      grant_id_d    = grant_id;
      to_cnt_d      = to_cnt;
      mem_request_d = mem_request;
      mem_we_re_d   = mem_we_re;
      mem_mask_d    = mem_mask;
      mem_address_d = mem_address;
      mem_wdata_d   = mem_wdata;
      ch_valid_d    = '0;
      ch_error_d    = 1'b0;
      ch_rdata_d    = ch_rdata;

      case (state)
         S_IDLE: begin
            if (win_found) begin
               mem_we_re_d   = ch_we_re[win_id];
               mem_mask_d    = ch_mask[win_id*MASK_W +: MASK_W];
               mem_address_d = ch_address[win_id*ADDR_W +: ADDR_W];
               mem_wdata_d   = ch_wdata[win_id*DATA_W +: DATA_W];
               grant_id_d    = win_id;
               last_grant_d  = win_id;
               mem_request_d = 1'b1;
               to_cnt_d      = '0;
               state_d       = S_BUSY;
            end
         end
         S_BUSY: begin
            // A completion in the timeout cycle still counts as a normal completion.
            if (mem_valid) begin
               ch_rdata_d    = mem_rdata;
               ch_valid_d    = NUM_CH'(1) << grant_id;
               mem_request_d = 1'b0;
               state_d       = S_RESP;
            end else if (TIMEOUT != 0 && to_cnt == CNT_LAST) begin
               ch_rdata_d    = '0;
               ch_valid_d    = NUM_CH'(1) << grant_id;
               ch_error_d    = 1'b1;
               mem_request_d = 1'b0;
               state_d       = S_RESP;
            end else if (TIMEOUT != 0) begin
               to_cnt_d = to_cnt + CNT_W'(1);
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state       <= S_IDLE;
         last_grant  <= GID_W'(NUM_CH - 1);
         grant_id    <= '0;
         to_cnt      <= '0;
         mem_request <= 1'b0;
         mem_we_re   <= 1'b0;
         mem_mask    <= '0;
         mem_address <= '0;
         mem_wdata   <= '0;
         ch_valid    <= '0;
         ch_error    <= 1'b0;
         ch_rdata    <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_d;
         last_grant  <= last_grant_d;
         grant_id    <= grant_id_d;
         to_cnt      <= to_cnt_d;
         mem_request <= mem_request_d;
         mem_we_re   <= mem_we_re_d;
         mem_mask    <= mem_mask_d;
         mem_address <= mem_address_d;
         mem_wdata   <= mem_wdata_d;
         ch_valid    <= ch_valid_d;
         ch_error    <= ch_error_d;
         ch_rdata    <= ch_rdata_d;
         busy        <= busy_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 is fixed priority, instance 1 round-robin,
// both with TIMEOUT=4. Completions are checked against a per-instance expectation queue.
module tb_mem_port_arbiter;

   typedef struct {
      int          ch;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   logic        rst         [2];
   logic [1:0]  ch_request  [2];
   logic [1:0]  ch_we_re    [2];
   logic [7:0]  ch_mask     [2];
   logic [63:0] ch_address  [2];
   logic [63:0] ch_wdata    [2];
   logic [1:0]  ch_valid    [2];
   logic        ch_error    [2];
   logic [31:0] ch_rdata    [2];
   logic        mem_request [2];
   logic        mem_we_re   [2];
   logic [3:0]  mem_mask    [2];
   logic [31:0] mem_address [2];
   logic [31:0] mem_wdata   [2];
   logic        mem_valid   [2];
   logic [31:0] mem_rdata   [2];
   logic [0:0]  grant_id    [2];
   logic        busy        [2];

   exp_t q0[$];
   exp_t q1[$];
   int   vcnt [2];
   int   n_pass  = 0;
   int   n_total = 0;

   mem_port_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MASK_W(4),
                      .PRIO_MODE(0), .TIMEOUT(4)) dut_fp (
      .clk(clk), .rst(rst[0]),
      .ch_request(ch_request[0]), .ch_we_re(ch_we_re[0]), .ch_mask(ch_mask[0]),
      .ch_address(ch_address[0]), .ch_wdata(ch_wdata[0]),
      .ch_valid(ch_valid[0]), .ch_error(ch_error[0]), .ch_rdata(ch_rdata[0]),
      .mem_request(mem_request[0]), .mem_we_re(mem_we_re[0]), .mem_mask(mem_mask[0]),
      .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]),
      .mem_valid(mem_valid[0]), .mem_rdata(mem_rdata[0]),
      .grant_id(grant_id[0]), .busy(busy[0])
   );

   mem_port_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MASK_W(4),
                      .PRIO_MODE(1), .TIMEOUT(4)) dut_rr (
      .clk(clk), .rst(rst[1]),
      .ch_request(ch_request[1]), .ch_we_re(ch_we_re[1]), .ch_mask(ch_mask[1]),
      .ch_address(ch_address[1]), .ch_wdata(ch_wdata[1]),
      .ch_valid(ch_valid[1]), .ch_error(ch_error[1]), .ch_rdata(ch_rdata[1]),
      .mem_request(mem_request[1]), .mem_we_re(mem_we_re[1]), .mem_mask(mem_mask[1]),
      .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]),
      .mem_valid(mem_valid[1]), .mem_rdata(mem_rdata[1]),
      .grant_id(grant_id[1]), .busy(busy[1])
   );

   // ---------------------------------------------------------------- scoreboard
   function automatic void push_exp(input int d, input int ch, input logic err,
                                    input logic [31:0] rdata);
      exp_t e;
      e.ch = ch; e.err = err; e.rdata = rdata;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   task automatic mon(input int d);
      exp_t       e;
      int         depth;
      logic [1:0] want_v;
      if (ch_valid[d] !== 2'b00) begin
         vcnt[d]++;
         n_total++;
         depth = (d == 0) ? q0.size() : q1.size();
         if (depth == 0) begin
            $display("FAIL mon%0d_unexpected: ch_valid=%b with no completion outstanding",
                     d, ch_valid[d]);
         end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            want_v = 2'b01 << e.ch;
            if ({ch_valid[d], ch_error[d], ch_rdata[d]} !== {want_v, e.err, e.rdata})
               $display("FAIL mon%0d_completion: valid=%b err=%b rdata=%h, want valid=%b err=%b rdata=%h",
                        d, ch_valid[d], ch_error[d], ch_rdata[d], want_v, e.err, e.rdata);
            else
               n_pass++;
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   // ---------------------------------------------------------------- drivers
   task automatic issue(input int d, input int ch, input logic we, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] wdata);
      ch_we_re[d][ch]             = we;
      ch_mask[d][ch*4 +: 4]       = mask;
      ch_address[d][ch*32 +: 32]  = addr;
      ch_wdata[d][ch*32 +: 32]    = wdata;
      ch_request[d][ch]           = 1'b1;
   endtask

   // Called on a negedge; returns on the first negedge with mem_request high.
   task automatic wait_req(input int d, input string tag);
      int n = 0;
      while (mem_request[d] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_total++;
      if (mem_request[d] !== 1'b1)
         $display("FAIL %s: mem_request=%b after 20 cycles, want 1", tag, mem_request[d]);
      else
         n_pass++;
   endtask

   // Called on the negedge of mem_request's first cycle; mem_valid goes high in
   // cycle 'lat' of the request. Returns on the negedge after the completion edge.
   task automatic mem_respond(input int d, input int lat, input logic [31:0] data);
      if (lat > 1) begin
         repeat (lat - 1) @(posedge clk);
         #1;
      end
      mem_valid[d] = 1'b1;
      mem_rdata[d] = data;
      @(posedge clk);
      #1 mem_valid[d] = 1'b0;
      mem_rdata[d] = 32'h0;
      @(negedge clk);
   endtask

   task automatic wait_valid(input int d, input string tag, input bit drop);
      int n = 0;
      while (ch_valid[d] === 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_total++;
      if (ch_valid[d] === 2'b00) begin
         $display("FAIL %s: ch_valid=%b after 20 cycles, want a pulse", tag, ch_valid[d]);
      end else begin
         n_pass++;
         if (drop) ch_request[d] = ch_request[d] & ~ch_valid[d];
      end
   endtask

   task automatic pulse_reset();
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      repeat (3) @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(negedge clk);
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      pulse_reset();
      for (int d = 0; d < 2; d++) begin
         n_total++;
         if ({mem_request[d], busy[d], ch_valid[d], ch_error[d], grant_id[d]} !== 6'b0)
            $display("FAIL reset_ctrl%0d: req=%b busy=%b valid=%b err=%b gid=%b, want all 0",
                     d, mem_request[d], busy[d], ch_valid[d], ch_error[d], grant_id[d]);
         else n_pass++;
         n_total++;
         if ({mem_we_re[d], mem_mask[d], mem_address[d], mem_wdata[d], ch_rdata[d]} !== 101'b0)
            $display("FAIL reset_data%0d: we=%b mask=%h addr=%h wdata=%h rdata=%h, want all 0",
                     d, mem_we_re[d], mem_mask[d], mem_address[d], mem_wdata[d], ch_rdata[d]);
         else n_pass++;
      end
   endtask

   task automatic test_single_read();
      int unsigned t_req, t_val;
      issue(0, 1, 1'b0, 32'h100, 4'hF, 32'h0);
      push_exp(0, 1, 1'b0, 32'hDEAD_BEEF);
      wait_req(0, "read_req");
      t_req = cyc;
      n_total++;
      if ({mem_we_re[0], mem_mask[0], mem_address[0], grant_id[0]} !== {1'b0, 4'hF, 32'h100, 1'b1})
         $display("FAIL read_fields: we=%b mask=%h addr=%h gid=%b, want 0 f 00000100 1",
                  mem_we_re[0], mem_mask[0], mem_address[0], grant_id[0]);
      else n_pass++;
      mem_respond(0, 2, 32'hDEAD_BEEF);
      wait_valid(0, "read_valid", 1'b1);
      t_val = cyc;
      n_total++;
      if (t_val - t_req !== 2)
         $display("FAIL read_latency: %0d cycles from mem_request to ch_valid, want 2", t_val - t_req);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({ch_valid[0], ch_error[0], ch_rdata[0]} !== {2'b00, 1'b0, 32'hDEAD_BEEF})
         $display("FAIL read_after_resp: valid=%b err=%b rdata=%h, want 00 0 deadbeef",
                  ch_valid[0], ch_error[0], ch_rdata[0]);
      else n_pass++;
   endtask

   task automatic test_fixed_priority();
      int unsigned t_val, t_req;
      @(negedge clk);
      issue(0, 0, 1'b0, 32'h200, 4'hF, 32'h0);
      issue(0, 1, 1'b0, 32'h204, 4'hF, 32'h0);
      push_exp(0, 0, 1'b0, 32'h0000_0A00);
      push_exp(0, 1, 1'b0, 32'h0000_0A01);
      wait_req(0, "fp_req0");
      n_total++;
      if ({grant_id[0], mem_address[0]} !== {1'b0, 32'h200})
         $display("FAIL fp_first: gid=%b addr=%h, want 0 00000200", grant_id[0], mem_address[0]);
      else n_pass++;
      mem_respond(0, 1, 32'h0000_0A00);
      wait_valid(0, "fp_valid0", 1'b1);
      t_val = cyc;
      wait_req(0, "fp_req1");
      t_req = cyc;
      n_total++;
      if ({grant_id[0], mem_address[0]} !== {1'b1, 32'h204})
         $display("FAIL fp_second: gid=%b addr=%h, want 1 00000204", grant_id[0], mem_address[0]);
      else n_pass++;
      n_total++;
      if (t_req - t_val !== 2)
         $display("FAIL fp_spacing: mem_request rose %0d cycles after ch_valid, want 2", t_req - t_val);
      else n_pass++;
      mem_respond(0, 1, 32'h0000_0A01);
      wait_valid(0, "fp_valid1", 1'b1);
   endtask

   task automatic test_round_robin();
      issue(1, 0, 1'b0, 32'h300, 4'hF, 32'h0);
      issue(1, 1, 1'b0, 32'h304, 4'hF, 32'h0);
      for (int k = 0; k < 4; k++) begin
         push_exp(1, k % 2, 1'b0, 32'h1000 + k);
         wait_req(1, "rr_req");
         n_total++;
         if (grant_id[1] !== 1'(k % 2))
            $display("FAIL rr_grant%0d: gid=%b, want %0d", k, grant_id[1], k % 2);
         else n_pass++;
         mem_respond(1, 1, 32'h1000 + k);
         wait_valid(1, "rr_valid", 1'b0);
      end
      ch_request[1] = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_write();
      logic [68:0] want;
      want = {1'b1, 4'b0011, 32'h20, 32'h1234_5678};
      issue(0, 0, 1'b1, 32'h20, 4'b0011, 32'h1234_5678);
      push_exp(0, 0, 1'b0, 32'h0BAD_F00D);
      wait_req(0, "wr_req");
      for (int k = 0; k < 3; k++) begin
         n_total++;
         if ({mem_we_re[0], mem_mask[0], mem_address[0], mem_wdata[0]} !== want)
            $display("FAIL wr_stable%0d: we=%b mask=%b addr=%h wdata=%h, want 1 0011 00000020 12345678",
                     k, mem_we_re[0], mem_mask[0], mem_address[0], mem_wdata[0]);
         else n_pass++;
         if (k < 2) begin
            // Channel inputs must be ignored while the transaction is in flight.
            ch_address[0][31:0] = 32'hFFFF_FFF0 + k;
            ch_wdata[0][31:0]   = 32'hA5A5_0000 + k;
            ch_mask[0][3:0]     = 4'b1100;
            ch_we_re[0][0]      = 1'b0;
            @(negedge clk);
         end
      end
      mem_respond(0, 1, 32'h0BAD_F00D);
      wait_valid(0, "wr_valid", 1'b1);
   endtask

   task automatic test_timeout();
      int          n = 0;
      int unsigned t_req, t_val;
      @(negedge clk);
      issue(0, 0, 1'b0, 32'h40, 4'hF, 32'h0);
      push_exp(0, 0, 1'b1, 32'h0);
      wait_req(0, "to_req");
      while (mem_request[0] === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      n_total++;
      if (n !== 4)
         $display("FAIL to_req_cycles: mem_request high %0d cycles, want 4", n);
      else n_pass++;
      wait_valid(0, "to_valid", 1'b1);
      @(negedge clk);
      n_total++;
      if ({busy[0], ch_valid[0], ch_error[0]} !== 4'b0)
         $display("FAIL to_idle: busy=%b valid=%b err=%b, want 0 00 0", busy[0], ch_valid[0], ch_error[0]);
      else n_pass++;
      // mem_valid in the 4th cycle beats the timeout.
      issue(0, 0, 1'b0, 32'h44, 4'hF, 32'h0);
      push_exp(0, 0, 1'b0, 32'hCAFE_0004);
      wait_req(0, "to_edge_req");
      t_req = cyc;
      mem_respond(0, 4, 32'hCAFE_0004);
      wait_valid(0, "to_edge_valid", 1'b1);
      t_val = cyc;
      n_total++;
      if (t_val - t_req !== 4)
         $display("FAIL to_edge_latency: %0d cycles, want 4", t_val - t_req);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int ch, v0;
      for (int d = 0; d < 2; d++) begin
         // Fixed instance is interrupted on ch1, round-robin on ch0 so that a
         // surviving last_grant would steer the next grant to ch1.
         ch = (d == 0) ? 1 : 0;
         v0 = vcnt[d];
         issue(d, ch, 1'b0, 32'h500, 4'hF, 32'h0);
         wait_req(d, "rm_req");
         n_total++;
         if (grant_id[d] !== 1'(ch))
            $display("FAIL rm_grant_before%0d: gid=%b, want %0d", d, grant_id[d], ch);
         else n_pass++;
         @(negedge clk);
         rst[d] = 1'b1;
         @(negedge clk);
         n_total++;
         if ({mem_request[d], busy[d], ch_valid[d]} !== 4'b0)
            $display("FAIL rm_abandon%0d: req=%b busy=%b valid=%b, want 0 0 00",
                     d, mem_request[d], busy[d], ch_valid[d]);
         else n_pass++;
         ch_request[d] = 2'b00;
         rst[d] = 1'b0;
         repeat (3) @(negedge clk);
         n_total++;
         if (vcnt[d] !== v0)
            $display("FAIL rm_no_valid%0d: %0d ch_valid pulses after reset, want 0", d, vcnt[d] - v0);
         else n_pass++;
         issue(d, 0, 1'b0, 32'h600, 4'hF, 32'h0);
         issue(d, 1, 1'b0, 32'h604, 4'hF, 32'h0);
         wait_req(d, "rm_req_after");
         n_total++;
         if (grant_id[d] !== 1'b0)
            $display("FAIL rm_grant_after%0d: gid=%b, want 0", d, grant_id[d]);
         else n_pass++;
         ch_request[d] = 2'b00;
         rst[d] = 1'b1;
         @(negedge clk);
         rst[d] = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1;
         ch_request[d] = '0; ch_we_re[d] = '0; ch_mask[d] = '0;
         ch_address[d] = '0; ch_wdata[d] = '0;
         mem_valid[d] = 1'b0; mem_rdata[d] = '0;
         vcnt[d] = 0;
      end
      @(negedge clk);
      test_reset();
      test_single_read();
      test_fixed_priority();
      test_round_robin();
      test_write();
      test_timeout();
      test_reset_mid();
      repeat (3) @(negedge clk);
      n_total++;
      if (q0.size() + q1.size() !== 0)
         $display("FAIL scoreboard_drain: %0d/%0d completions never seen, want 0/0", q0.size(), q1.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised memory-port arbiter that merges `NUM_CH` requestor channels onto one memory port. Typical requestors are the core's instruction-fetch and data (load/store) paths, plus any later DMA or debug masters. It uses the core's request/valid handshake and byte-mask signalling. It adds three things the core's separate ports do not have:

- a selectable arbitration mode (fixed priority or round-robin);
- registered request latching;
- a per-transaction timeout with an error response.

## Interface
Parameters:
- `NUM_CH`, 2, number of requestor channels (≥2).
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width (multiple of 8).
- `MASK_W`, `DATA_W/8`, byte-mask width.
- `PRIO_MODE`, 0, 0 = fixed priority (ch0 highest), 1 = round-robin.
- `TIMEOUT`, 0, cycles to wait for `mem_valid` before erroring; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ch_request`  in  `NUM_CH`  per-channel request; held until that channel's `ch_valid`.
- `ch_we_re`  in  `NUM_CH`  1 = write (store), 0 = read (load).
- `ch_mask`  in  `NUM_CH*MASK_W`  byte masks, channel i at `[i*MASK_W +: MASK_W]`.
- `ch_address`  in  `NUM_CH*ADDR_W`  addresses, packed the same way.
- `ch_wdata`  in  `NUM_CH*DATA_W`  write data, packed the same way.
- `ch_valid`  out  `NUM_CH`  one-cycle completion pulse, one-hot.
- `ch_error`  out  1  qualifies `ch_valid`: 1 means the transaction timed out.
- `ch_rdata`  out  `DATA_W`  read data, shared by all channels, valid with `ch_valid`.
- `mem_request`  out  1  memory request.
- `mem_we_re`  out  1  latched direction.
- `mem_mask`  out  `MASK_W`  latched byte mask.
- `mem_address`  out  `ADDR_W`  latched address.
- `mem_wdata`  out  `DATA_W`  latched write data.
- `mem_valid`  in  1  memory completion; `mem_rdata` is valid in this cycle.
- `mem_rdata`  in  `DATA_W`  memory read data.
- `grant_id`  out  `$clog2(NUM_CH)`  currently or last granted channel.
- `busy`  out  1  state != IDLE.

## Operation
State machine has three states: IDLE, BUSY, RESP.

IDLE:
- If any `ch_request` is set, select a winner.
  - `PRIO_MODE`=0: lowest index wins.
  - `PRIO_MODE`=1: first requesting channel searching from `last_grant+1` modulo `NUM_CH`.
- Latch the winner's `we_re`, `mask`, `address` and `wdata` into the `mem_*` registers.
- Set `grant_id` and `last_grant` to the winner, assert `mem_request`, go to BUSY.
- With no request, stay in IDLE.

BUSY:
- Hold `mem_request` and all latched fields stable. Ignore channel inputs.
- On `mem_valid`:
  - Register `mem_rdata` into `ch_rdata`.
  - Drive `ch_valid[grant_id]`=1 and `ch_error`=0.
  - Drop `mem_request`, go to RESP.
- If `TIMEOUT`≠0: a counter of width `$clog2(TIMEOUT+1)` is cleared on entry to BUSY and increments each BUSY cycle without `mem_valid`. When the count reaches `TIMEOUT`:
  - Drop `mem_request`.
  - Set `ch_valid[grant_id]`=1, `ch_error`=1, `ch_rdata`=0.
  - Go to RESP.
- `mem_valid` and timeout in the same cycle: `mem_valid` wins and no error is signalled.

RESP:
- `ch_valid`, `ch_error` and `ch_rdata` are visible for exactly this one cycle.
- Next state is IDLE.
- `ch_valid` and `ch_error` clear on leaving RESP. `ch_rdata` holds until the next completion.

Requestor rule:
- A requestor must deassert `ch_request` in the IDLE cycle following its `ch_valid` unless it is issuing a new transaction.
- A request held across that cycle is treated as a new transaction.

`mem_valid` outside BUSY is ignored.

Reset (synchronous, active-high):
- State goes to IDLE.
- `mem_request`, `mem_we_re`, `mem_mask`, `mem_address`, `mem_wdata`, `ch_valid`, `ch_error`, `ch_rdata`, `grant_id`, `busy` and the timeout counter all reset to 0.
- `last_grant` resets to `NUM_CH-1`, so ch0 is searched first in round-robin mode.
- Reset during BUSY abandons the transaction: no `ch_valid` is issued and `mem_request` is low from the next edge.

## Timing
- Requests are sampled at edge E0 while in IDLE. `mem_request` is high from E0+1.
- If `mem_valid` is high in the cycle ending at edge Ek (k≥1), `ch_valid` is high from Ek until Ek+1.
- Minimum request-to-`ch_valid` latency is 2 cycles.
- Minimum spacing between grants is 3 cycles.
- A timeout fires `TIMEOUT` cycles after `mem_request` rises.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- **Single read:** `NUM_CH`=2, ch1 reads address 0x100 with mask 4'hF; memory returns 0xDEADBEEF 2 cycles after `mem_request` → `mem_address`=0x100 and `mem_we_re`=0; `ch_valid`=2'b10 for one cycle with `ch_rdata`=0xDEADBEEF and `ch_error`=0.
- **Fixed priority:** `PRIO_MODE`=0, ch0 and ch1 request in the same cycle → ch0 is served first. ch1 is served next and its `mem_request` rises 2 cycles after ch0's `ch_valid`.
- **Round-robin:** `PRIO_MODE`=1, both channels issue back-to-back requests for 4 transactions → `grant_id` sequence is 0,1,0,1.
- **Write pass-through:** ch0 write to address 0x20 with wdata 0x12345678 and mask 4'b0011 → `mem_we_re`=1, `mem_mask`=4'b0011 and `mem_wdata`=0x12345678, stable until `mem_valid`.
- **Timeout:** `TIMEOUT`=4, `mem_valid` held low → `mem_request` high for exactly 4 cycles, then `ch_valid`=1 with `ch_error`=1 and `ch_rdata`=0, then IDLE. A repeat run with `mem_valid` arriving on the 4th cycle → normal completion with `ch_error`=0.
- **Reset mid-transaction:** `rst` asserted during BUSY → `mem_request` is 0 the next cycle, no `ch_valid` pulse, `busy`=0. The next request after reset is granted to ch0 in both modes.
